// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: ROWS x COLS output-stationary MAC grid with input skew, valid/ready operand stream and row-serial results.
// Optional macro SYSTOLIC_SAT_EN: saturating accumulation with sticky sat flag; undefined builds wrap and tie sat low.
module systolic_mm_engine #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int KLEN_W = 16,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [KLEN_W-1:0]       k_len,
    input  logic                    signed_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*DATA_W-1:0]  a_data,
    input  logic [COLS*DATA_W-1:0]  b_data,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [COLS*ACC_W-1:0]   c_data,
    output logic [RW-1:0]           c_row,
    output logic                    c_last,
    output logic                    busy,
    output logic                    done,
    output logic                    sat
);
    localparam int PW  = 2 * DATA_W;
    localparam int DN  = ROWS + COLS - 1;
    localparam int DCW = $clog2(DN + 1);

    typedef enum logic [2:0] {IDLE, FEED, DRAIN, OUT, FIN} state_t;

    state_t                 r_state, w_next;
    logic [KLEN_W-1:0]      r_klen, r_cnt;
    logic [DCW-1:0]         r_dcnt;
    logic [RW-1:0]          r_row;
    logic                   r_sm;
    logic                   w_beat, w_last_beat, w_row_acc, w_clr;
    logic [ROWS*DATA_W-1:0] w_a_beat;
    logic [COLS*DATA_W-1:0] w_b_beat;
    logic [DATA_W-1:0]      w_a_in [ROWS];
    logic [DATA_W-1:0]      w_b_in [COLS];
    logic [DATA_W-1:0]      r_ah   [ROWS][COLS];
    logic [DATA_W-1:0]      r_bv   [ROWS][COLS];
    logic [DATA_W-1:0]      w_ah   [ROWS][COLS+1];
    logic [DATA_W-1:0]      w_bv   [ROWS+1][COLS];
    logic [ACC_W-1:0]       r_acc  [ROWS][COLS];
    logic [ACC_W-1:0]       w_sum  [ROWS][COLS];

    function automatic logic [ACC_W-1:0] prod(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic sm);
        logic signed [PW-1:0] ps;
        logic [PW-1:0]        pu;
        ps = PW'($signed(a)) * PW'($signed(b));
        pu = PW'(a) * PW'(b);
        return sm ? ACC_W'(ps) : ACC_W'(pu);
    endfunction

    assign w_beat      = (r_state == FEED) && in_valid;
    assign w_last_beat = w_beat && (r_cnt == r_klen - 1'b1);
    assign w_row_acc   = (r_state == OUT) && c_ready;
    assign w_clr       = (r_state == IDLE) && start;
    assign w_a_beat    = w_beat ? a_data : '0;
    assign w_b_beat    = w_beat ? b_data : '0;

    assign in_ready = (r_state == FEED);
    assign c_valid  = (r_state == OUT);
    assign c_last   = c_valid && (r_row == RW'(ROWS - 1));
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == FIN);
    assign c_row    = r_row;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (k_len == '0) ? OUT : FEED;
            FEED:    if (w_last_beat) w_next = DRAIN;
            DRAIN:   if (r_dcnt == DCW'(DN - 1)) w_next = OUT;
            OUT:     if (w_row_acc && r_row == RW'(ROWS - 1)) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_klen  <= '0;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_row   <= '0;
            r_sm    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_dcnt  <= (r_state == DRAIN) ? r_dcnt + 1'b1 : '0;
            if (w_clr) begin
                r_klen <= k_len;
                r_sm   <= signed_mode;
                r_cnt  <= '0;
                r_row  <= '0;
            end
            if (w_beat) r_cnt <= r_cnt + 1'b1;
            if (w_row_acc) r_row <= r_row + 1'b1;
        end
    end

    // Lane r of A and lane c of B enter the grid r resp. c cycles late; idle cycles push zeros.
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        if (r == 0) begin : g_d0
            assign w_a_in[r] = w_a_beat[r*DATA_W +: DATA_W];
        end else begin : g_dn
            logic [DATA_W-1:0] r_sr [r];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int j = 0; j < r; j++) r_sr[j] <= '0;
                end else begin
                    r_sr[0] <= w_a_beat[r*DATA_W +: DATA_W];
                    for (int j = 1; j < r; j++) r_sr[j] <= r_sr[j-1];
                end
            end
            assign w_a_in[r] = r_sr[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        if (c == 0) begin : g_d0
            assign w_b_in[c] = w_b_beat[c*DATA_W +: DATA_W];
        end else begin : g_dn
            logic [DATA_W-1:0] r_sr [c];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int j = 0; j < c; j++) r_sr[j] <= '0;
                end else begin
                    r_sr[0] <= w_b_beat[c*DATA_W +: DATA_W];
                    for (int j = 1; j < c; j++) r_sr[j] <= r_sr[j-1];
                end
            end
            assign w_b_in[c] = r_sr[c-1];
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            w_ah[r][0] = w_a_in[r];
            for (int c = 0; c < COLS; c++) w_ah[r][c+1] = r_ah[r][c];
        end
        for (int c = 0; c < COLS; c++) begin
            w_bv[0][c] = w_b_in[c];
            for (int r = 0; r < ROWS; r++) w_bv[r+1][c] = r_bv[r][c];
        end
    end

`ifdef SYSTOLIC_SAT_EN
    logic                 r_sat;
    logic [ROWS*COLS-1:0] w_ovf;

    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc, input logic [ACC_W-1:0] p, input logic sm);
        logic [ACC_W:0] s;
        logic           ovf;
        s   = sm ? {acc[ACC_W-1], acc} + {p[ACC_W-1], p} : {1'b0, acc} + {1'b0, p};
        ovf = sm ? (s[ACC_W] ^ s[ACC_W-1]) : s[ACC_W];
        return {ovf, !ovf ? s[ACC_W-1:0] : sm ? {s[ACC_W], {(ACC_W-1){!s[ACC_W]}}} : {ACC_W{1'b1}}};
    endfunction

    always_comb begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                {w_ovf[r*COLS+c], w_sum[r][c]} = sat_add(r_acc[r][c], prod(w_ah[r][c], w_bv[r][c], r_sm), r_sm);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_clr) r_sat <= 1'b0;
        else if (|w_ovf) r_sat <= 1'b1;
    end

    assign sat = r_sat;
`else
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                w_sum[r][c] = r_acc[r][c] + prod(w_ah[r][c], w_bv[r][c], r_sm);
    end

    assign sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    r_ah[r][c]  <= '0;
                    r_bv[r][c]  <= '0;
                    r_acc[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    r_ah[r][c]  <= w_ah[r][c];
                    r_bv[r][c]  <= w_bv[r][c];
                    r_acc[r][c] <= w_clr ? '0 : w_sum[r][c];
                end
        end
    end

    always_comb begin
        c_data = '0;
        for (int c = 0; c < COLS; c++)
            if (c_valid) c_data[c*ACC_W +: ACC_W] = r_acc[r_row][c];
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: randomized self-checking bench; a 32-bit and a 16-bit accumulator engine share every stimulus
// and are both compared against an arithmetic matrix-product model.
module tb_systolic_mm_engine;
    localparam int R = 8, C = 8, DW = 8, MAXK = 32;
`ifdef SYSTOLIC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_mode = 1'b0, in_valid = 1'b0, c_ready = 1'b0;
    logic [15:0] k_len = '0;
    logic [R*DW-1:0] a_data = '0;
    logic [C*DW-1:0] b_data = '0;
    logic in_ready, c_valid, c_last, busy, done, sat;
    logic in_ready16, c_valid16, c_last16, busy16, done16, sat16;
    logic [C*32-1:0] c_data;
    logic [C*16-1:0] c_data16;
    logic [2:0] c_row, c_row16;

    logic [7:0] ma [R][MAXK];
    logic [7:0] mb [MAXK][C];
    longint got32 [R][C];
    longint got16 [R][C];
    int checks = 0, errors = 0, cycnt = 0;

    systolic_mm_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .c_row(c_row), .c_last(c_last),
        .busy(busy), .done(done), .sat(sat)
    );

    systolic_mm_engine #(.ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready16), .a_data(a_data), .b_data(b_data),
        .c_valid(c_valid16), .c_ready(c_ready), .c_data(c_data16), .c_row(c_row16), .c_last(c_last16),
        .busy(busy16), .done(done16), .sat(sat16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycnt <= cycnt + 1;

    function automatic longint model(input int r, input int c, input int k, input bit sm, input int w, inout bit clip);
        longint acc, p, hi, lo, mask;
        acc  = 0;
        mask = (longint'(1) << w) - 1;
        hi   = sm ? (longint'(1) << (w - 1)) - 1 : mask;
        lo   = sm ? -(longint'(1) << (w - 1)) : 0;
        for (int i = 0; i < k; i++) begin
            p = sm ? longint'($signed(ma[r][i])) * longint'($signed(mb[i][c])) : longint'(ma[r][i]) * longint'(mb[i][c]);
            acc += p;
            if (SAT && acc > hi) begin acc = hi; clip = 1'b1; end
            if (SAT && acc < lo) begin acc = lo; clip = 1'b1; end
        end
        return acc & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string name, input int k, input bit sm, input bit toggle, input int stall_row, input bit poke);
        longint e32 [R][C];
        longint e16 [R][C];
        bit s32, s16, rdy_ok, bad;
        int idx, cyc, e_acc, rows, stall, lat;
        s32 = 1'b0;
        s16 = 1'b0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                e32[r][c] = model(r, c, k, sm, 32, s32);
                e16[r][c] = model(r, c, k, sm, 16, s16);
            end
        start = 1'b1;
        k_len = 16'(k);
        signed_mode = sm;
        tick();
        checks++;
        if (busy !== 1'b1 || busy16 !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start got %b/%b want 1", name, busy, busy16);
        end
        start = poke;
        k_len = 16'($urandom_range(1, 40));
        signed_mode = ~sm;
        idx = 0; cyc = 0; rdy_ok = 1'b1; e_acc = cycnt;
        while (idx < k && cyc < 400) begin
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            for (int r = 0; r < R; r++) a_data[r*DW +: DW] = in_valid ? ma[r][idx] : 8'($urandom);
            for (int c = 0; c < C; c++) b_data[c*DW +: DW] = in_valid ? mb[idx][c] : 8'($urandom);
            if (in_ready !== 1'b1 || in_ready16 !== 1'b1) rdy_ok = 1'b0;
            tick();
            if (in_valid) begin idx++; e_acc = cycnt; end
            cyc++;
        end
        in_valid = 1'b0;
        a_data = R*DW'($urandom);
        b_data = C*DW'($urandom);
        checks++;
        if (idx != k || !rdy_ok) begin
            errors++;
            $display("FAIL %s feed beats got %0d want %0d in_ready_ok %b", name, idx, k, rdy_ok);
        end
        if (k > 0) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s in_ready_after_last got %b want 0", name, in_ready);
            end
        end
        cyc = 0;
        while (c_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        lat = cycnt - e_acc + 1;
        if (k > 0) begin
            checks++;
            if (lat != R + C) begin
                errors++;
                $display("FAIL %s latency got %0d want %0d", name, lat, R + C);
            end
        end
        rows = 0; stall = 0; cyc = 0;
        while (rows < R && cyc < 200) begin
            if (c_valid === 1'b1 && c_valid16 === 1'b1) begin
                if (int'(c_row) == stall_row && stall < 3) begin c_ready = 1'b0; stall++; end
                else c_ready = 1'b1;
                bad = (c_row !== 3'(rows)) || (c_row16 !== 3'(rows)) || (c_last !== (rows == R - 1)) || (c_last16 !== (rows == R - 1));
                for (int c = 0; c < C; c++) begin
                    if (c_data[c*32 +: 32] !== 32'(e32[rows][c]) || c_data16[c*16 +: 16] !== 16'(e16[rows][c])) bad = 1'b1;
                    if (c_ready) begin
                        got32[rows][c] = longint'(c_data[c*32 +: 32]);
                        got16[rows][c] = longint'(c_data16[c*16 +: 16]);
                    end
                end
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL %s row%0d got row %0d/%0d last %b lane0 %h/%h want row %0d lane0 %h/%h", name, rows, c_row, c_row16,
                             c_last, c_data[31:0], c_data16[15:0], rows, 32'(e32[rows][0]), 16'(e16[rows][0]));
                end
            end else c_ready = 1'b0;
            tick();
            if (c_ready) rows++;
            cyc++;
        end
        c_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (rows != R || done !== 1'b1 || done16 !== 1'b1) begin
            errors++;
            $display("FAIL %s rows/done got %0d rows done %b/%b want %0d rows done 1", name, rows, done, done16, R);
        end
        checks++;
        if (sat !== (SAT & s32) || sat16 !== (SAT & s16)) begin
            errors++;
            $display("FAIL %s sat got %b/%b want %b/%b", name, sat, sat16, SAT & s32, SAT & s16);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done16 !== 1'b0 || busy16 !== 1'b0) begin
            errors++;
            $display("FAIL %s after_fin done %b busy %b want 0 0", name, done, busy);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < R; i++)
            for (int k = 0; k < 8; k++) ma[i][k] = 8'(8 * i + k + 1);
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < C; j++) mb[k][j] = ma[j][k];
    endtask

    task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < R; i++)
            for (int k = 0; k < MAXK; k++) ma[i][k] = av;
        for (int k = 0; k < MAXK; k++)
            for (int j = 0; j < C; j++) mb[k][j] = bv;
    endtask

    task automatic fill_random();
        for (int i = 0; i < R; i++)
            for (int k = 0; k < MAXK; k++) ma[i][k] = 8'($urandom);
        for (int k = 0; k < MAXK; k++)
            for (int j = 0; j < C; j++) mb[k][j] = 8'($urandom);
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({in_ready, c_valid, c_last, busy, done, sat, c_row} !== '0 || c_data !== '0 ||
            {in_ready16, c_valid16, c_last16, busy16, done16, sat16, c_row16} !== '0 || c_data16 !== '0) begin
            errors++;
            $display("FAIL reset outputs got ctl %b%b%b%b%b%b row %0d data %h want all 0", in_ready, c_valid, c_last, busy, done, sat, c_row, c_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        fill_pattern();
        run_job("basic", 8, 1'b0, 1'b0, -1, 1'b0);
        checks++;
        if (got32[0][0] != 204 || got32[0][7] != 2220 || got32[7][7] != 29324) begin
            errors++;
            $display("FAIL basic_consts got %0d %0d %0d want 204 2220 29324", got32[0][0], got32[0][7], got32[7][7]);
        end
    endtask

    task automatic test_toggle();
        fill_pattern();
        run_job("toggle", 8, 1'b0, 1'b1, -1, 1'b0);
        checks++;
        if (got32[0][0] != 204 || got32[7][7] != 29324) begin
            errors++;
            $display("FAIL toggle_consts got %0d %0d want 204 29324", got32[0][0], got32[7][7]);
        end
    endtask

    task automatic test_backpressure();
        fill_pattern();
        run_job("stall", 8, 1'b0, 1'b0, 2, 1'b0);
    endtask

    task automatic test_signed_mode();
        fill_const(8'hFF, 8'h02);
        run_job("signed", 4, 1'b1, 1'b0, -1, 1'b0);
        checks++;
        if (got32[3][5] != longint'(32'hFFFFFFF8)) begin
            errors++;
            $display("FAIL signed_const got %h want fffffff8", got32[3][5]);
        end
        run_job("unsigned", 4, 1'b0, 1'b0, -1, 1'b0);
        checks++;
        if (got32[6][1] != 2040) begin
            errors++;
            $display("FAIL unsigned_const got %0d want 2040", got32[6][1]);
        end
    endtask

    task automatic test_saturation();
        fill_const(8'h80, 8'h80);
        run_job("sat", 4, 1'b1, 1'b0, -1, 1'b0);
        checks++;
        if (got16[2][4] != (SAT ? 32767 : 0) || got32[2][4] != 65536) begin
            errors++;
            $display("FAIL sat_const got %0d/%0d want %0d/65536", got16[2][4], got32[2][4], SAT ? 32767 : 0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_job("random", $urandom_range(0, 20), 1'($urandom), 1'($urandom), $urandom_range(0, 9), 1'b0);
        end
    endtask

    task automatic test_abort_restart();
        bit seen_done;
        fill_random();
        start = 1'b1;
        k_len = 16'd8;
        signed_mode = 1'b0;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || busy16 !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset busy %b done %b in_ready %b want 0 0 0", busy, done, in_ready);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1 || done16 === 1'b1) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL abort_no_done got done pulse want none");
        end
        fill_const(8'd3, 8'd3);
        run_job("restart", 1, 1'b0, 1'b0, -1, 1'b1);
        checks++;
        if (got32[0][0] != 9 || got32[7][7] != 9) begin
            errors++;
            $display("FAIL restart_consts got %0d %0d want 9 9", got32[0][0], got32[7][7]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_backpressure();
        test_signed_mode();
        test_saturation();
        test_random();
        test_abort_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
